clk_meter: RTL and testbench

- Receive-side companion to the clock divider.
- Takes a divided or external clock-like signal that is asynchronous to the system clock and synchronizes it into the system clock domain.
- Detects its rising edges and reports two measurements:
  - rising-edge count per fixed gate window, delivered over a valid/ready handshake;
  - most recent edge-to-edge period, in system clock cycles.
- Used for bring-up self-check of generated clocks and for peripheral clock-presence monitoring.

---
 rtl/clk_meter_pkg.sv | 13 +
 rtl/clk_meter_sync_rise.sv | 39 +++
 rtl/clk_meter.sv | 141 ++++++++++++++
 tb/tb_clk_meter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock meter.
// The result record is sized for the default counter width; CNT_W must not exceed it.
package clk_meter_pkg;

   localparam int CNT_W_DEF = 16;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] edges;
      logic                 sat;
      logic                 overrun;
   } meas_t;

endpackage

// File: rtl/clk_meter_sync_rise.sv
// Multi-flop synchronizer for an asynchronous level with a registered rising-edge pulse.
// Reusable for any asynchronous input.
module sync_rise #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;
   logic                   rise_q, rise_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      dly_d  = sync_q[SYNC_STAGES-1];
      // Pulse is registered so it is glitch-free: SYNC_STAGES+1 cycles after the sampled high.
      rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
         rise_q <= rise_d;
      end
   end

   assign q    = sync_q[SYNC_STAGES-1];
   assign rise = rise_q;

endmodule

// File: rtl/clk_meter.sv
// Measures an asynchronous clock-like input: edges per gate window (valid/ready),
// last edge-to-edge period, and a stall indication.
module clk_meter
   import clk_meter_pkg::*;
#(
   parameter int GATE_CYCLES  = 1000,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int SYNC_STAGES  = 2,
   parameter int STALL_CYCLES = 4096
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] meas_edges,
   output logic             meas_sat,
   output logic             meas_overrun,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             stalled
);

   localparam int             WIN_W   = $clog2(GATE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             rise;
   logic             sync_unused;

   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] edge_q, edge_d;
   logic             sat_q, sat_d;
   meas_t            res_q, res_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pv_q, pv_d;
   logic             seen_q, seen_d;
   logic             stalled_q, stalled_d;

   logic             terminal;
   logic             xfer;
   logic             stall_hit;
   logic [CNT_W-1:0] edges_now;
   logic             sat_now;

   sync_rise #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_in(clk_in),
      .rst   (rst),
      .d     (sig_in),
      .q     (sync_unused),
      .rise  (rise)
   );

   always_comb begin
      terminal = (win_q == WIN_W'(GATE_CYCLES - 1));
      xfer     = valid_q & meas_ready;
      win_d    = terminal ? '0 : win_q + WIN_W'(1);

      edges_now = edge_q;
      sat_now   = sat_q;
      if (rise) begin
         if (edge_q == CNT_MAX) sat_now = 1'b1;
         else                   edges_now = edge_q + CNT_W'(1);
      end

      res_d   = res_q;
      valid_d = valid_q;
      edge_d  = edges_now;
      sat_d   = sat_now;
      // A terminal cycle wins over a transfer: fresh data loads and valid stays high.
      if (terminal) begin
         res_d.edges   = CNT_W_DEF'(edges_now);
         res_d.sat     = sat_now;
         res_d.overrun = valid_q & ~meas_ready;
         valid_d       = 1'b1;
         edge_d        = '0;
         sat_d         = 1'b0;
      end else if (xfer) begin
         valid_d       = 1'b0;
         res_d.overrun = 1'b0;
      end
   end

   always_comb begin
      per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
      period_d  = period_q;
      pv_d      = pv_q;
      seen_d    = seen_q | rise;
      if (rise) begin
         per_cnt_d = CNT_W'(1);
         if (seen_q) begin
            period_d = per_cnt_q;
            pv_d     = 1'b1;
         end
      end

      stall_hit = (per_cnt_q == CNT_W'(STALL_CYCLES)) |
                  (~seen_q & (32'(win_q) == 32'(STALL_CYCLES)));
      stalled_d = stalled_q;
      if (rise)           stalled_d = 1'b0;
      else if (stall_hit) stalled_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         win_q     <= '0;
         edge_q    <= '0;
         sat_q     <= 1'b0;
         res_q     <= '0;
         valid_q   <= 1'b0;
         per_cnt_q <= '0;
         period_q  <= '0;
         pv_q      <= 1'b0;
         seen_q    <= 1'b0;
         stalled_q <= 1'b0;
      end else begin
         win_q     <= win_d;
         edge_q    <= edge_d;
         sat_q     <= sat_d;
         res_q     <= res_d;
         valid_q   <= valid_d;
         per_cnt_q <= per_cnt_d;
         period_q  <= period_d;
         pv_q      <= pv_d;
         seen_q    <= seen_d;
         stalled_q <= stalled_d;
      end
   end

   assign meas_valid   = valid_q;
   assign meas_edges   = CNT_W'(res_q.edges);
   assign meas_sat     = res_q.sat;
   assign meas_overrun = res_q.overrun;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign stalled      = stalled_q;

endmodule

// File: tb/tb_clk_meter.sv
// Directed bench for clk_meter: a 16-bit instance for windows, handshake, period,
// stall and reset, plus a 4-bit instance for edge-count saturation.
module tb_clk_meter;
   import clk_meter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig1 = 1'b0, sig2 = 1'b0;
   logic        rdy1 = 1'b1, rdy2 = 1'b1;

   logic        valid1, sat1, ovr1, pv1, stl1;
   logic [15:0] edges1, per1;
   logic        valid2, sat2, ovr2, pv2, stl2;
   logic [3:0]  edges2, per2;

   logic        en1 = 1'b0, en2 = 1'b0;
   logic [1:0]  ph1 = 2'd0;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   clk_meter #(
      .GATE_CYCLES (100),
      .CNT_W       (16),
      .SYNC_STAGES (2),
      .STALL_CYCLES(64)
   ) dut1 (
      .clk_in      (clk),
      .rst         (rst),
      .sig_in      (sig1),
      .meas_valid  (valid1),
      .meas_ready  (rdy1),
      .meas_edges  (edges1),
      .meas_sat    (sat1),
      .meas_overrun(ovr1),
      .period      (per1),
      .period_valid(pv1),
      .stalled     (stl1)
   );

   clk_meter #(
      .GATE_CYCLES (100),
      .CNT_W       (4),
      .SYNC_STAGES (2),
      .STALL_CYCLES(12)
   ) dut2 (
      .clk_in      (clk),
      .rst         (rst),
      .sig_in      (sig2),
      .meas_valid  (valid2),
      .meas_ready  (rdy2),
      .meas_edges  (edges2),
      .meas_sat    (sat2),
      .meas_overrun(ovr2),
      .period      (per2),
      .period_valid(pv2),
      .stalled     (stl2)
   );

   always #5 clk = ~clk;

   // sig1 toggles every 2 cycles, sig2 every cycle, while enabled
   initial begin
      forever begin
         @(negedge clk);
         if (en1) begin
            ph1  = ph1 + 2'd1;
            sig1 = ph1[1];
         end
         if (en2) sig2 = ~sig2;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish (errors=%0d of %0d)", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_to(input int unsigned c);
      while (cyc < c) tick(1);
   endtask

   task automatic chk_zero(input string tag);
      meas_t m;
      m = '{edges: edges1, sat: sat1, overrun: ovr1};
      chk({tag, "_meas"}, 32'(m), 32'd0);
      chk({tag, "_flags"}, {27'd0, valid1, pv1, stl1, valid2, pv2}, 32'd0);
      chk({tag, "_period"}, 32'(per1), 32'd0);
   endtask

   initial begin
      int unsigned first;
      int unsigned nr;

      rst = 1'b1;
      tick(3);
      chk_zero("reset");
      rst = 1'b0;
      cyc = 0;

      // idle input: empty windows, stall via window counter
      run_to(64);  chk("idle_stall_before", 32'(stl1), 32'd0);
      run_to(65);  chk("idle_stall_set", 32'(stl1), 32'd1);
      run_to(99);  chk("idle_valid_pre", 32'(valid1), 32'd0);
      run_to(100);
      chk("idle_valid", 32'(valid1), 32'd1);
      chk("idle_edges", 32'(edges1), 32'd0);
      chk("idle_sat", 32'(sat1), 32'd0);
      chk("idle_pv", 32'(pv1), 32'd0);
      run_to(101); chk("idle_xfer_drop", 32'(valid1), 32'd0);
      en1 = 1'b1;
      en2 = 1'b1;

      run_to(190);
      en2  = 1'b0;
      sig2 = 1'b0;
      run_to(200);
      chk("tog_valid", 32'(valid1), 32'd1);
      chk("tog_edges_range", 32'(edges1 >= 16'd24 && edges1 <= 16'd26), 32'd1);
      chk("tog_period", 32'(per1), 32'd4);
      chk("tog_pv", 32'(pv1), 32'd1);
      chk("tog_stalled", 32'(stl1), 32'd0);
      chk("sat_edges", 32'(edges2), 32'd15);
      chk("sat_flag", 32'(sat2), 32'd1);

      // hold ready low across two windows
      run_to(201);
      chk("tog_xfer_drop", 32'(valid1), 32'd0);
      rdy1 = 1'b0;
      run_to(300);
      chk("hold1_valid", 32'(valid1), 32'd1);
      chk("hold1_ovr", 32'(ovr1), 32'd0);
      chk("nosat_edges", 32'(edges2), 32'd0);
      chk("nosat_flag", 32'(sat2), 32'd0);
      run_to(350); chk("hold_mid_valid", 32'(valid1), 32'd1);
      run_to(400);
      chk("hold2_valid", 32'(valid1), 32'd1);
      chk("hold2_ovr", 32'(ovr1), 32'd1);
      chk("hold2_edges_range", 32'(edges1 >= 16'd24 && edges1 <= 16'd26), 32'd1);
      rdy1 = 1'b1;
      tick(1);
      rdy1 = 1'b0;
      chk("pulse_xfer_valid", 32'(valid1), 32'd0);
      chk("pulse_xfer_ovr", 32'(ovr1), 32'd0);
      run_to(500); chk("w5_ovr", 32'(ovr1), 32'd0);
      run_to(599);
      rdy1 = 1'b1;
      run_to(600);
      rdy1 = 1'b0;
      chk("coincide_valid", 32'(valid1), 32'd1);
      chk("coincide_ovr", 32'(ovr1), 32'd0);
      run_to(601); chk("coincide_hold", 32'(valid1), 32'd1);

      // reset mid-window with a pending result
      run_to(640);
      en1  = 1'b0;
      sig1 = 1'b0;
      run_to(650);
      chk("pre_rst_valid", 32'(valid1), 32'd1);
      rst = 1'b1;
      tick(1);
      chk_zero("midrst");
      rst = 1'b0;
      cyc = 0;

      // single 3-cycle pulse: latency and single rise
      run_to(9);
      @(negedge clk);
      sig1  = 1'b1;
      first = 0;
      nr    = 0;
      for (int unsigned k = 1; k <= 10; k++) begin
         tick(1);
         if (k == 3) sig1 = 1'b0;
         if (dut1.u_sync.rise) begin
            nr++;
            if (first == 0) first = k;
         end
      end
      chk("rise_latency", first, 32'd3);
      chk("rise_count", nr, 32'd1);
      chk("post_rst_pv_one", 32'(pv1), 32'd0);

      run_to(29);
      @(negedge clk);
      sig1 = 1'b1;
      run_to(32);
      sig1 = 1'b0;
      run_to(34);
      chk("post_rst_pv_two", 32'(pv1), 32'd1);
      chk("post_rst_period", 32'(per1), 32'd20);
      run_to(100);
      chk("post_rst_valid", 32'(valid1), 32'd1);
      chk("post_rst_edges", 32'(edges1), 32'd2);
      chk("post_rst_sat", 32'(sat1), 32'd0);
      chk("post_rst_ovr", 32'(ovr1), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
